// File: rtl/dataset_row_streamer.sv
// Row buffer between the deserializer and the regression engine: captures packed rows,
// then replays them field by field over a valid/ready handshake.
module dataset_row_streamer #(
  parameter int ADDR_WIDTH   = 12,
  parameter int MAX_FEATURES = 15,
  parameter int FIELD_W      = 16,
  parameter int DATA_WIDTH   = FIELD_W*(MAX_FEATURES+1),
  parameter int DEPTH        = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [11:0]           i_num_dp,
  input  logic [3:0]            i_feat,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_load_done,
  input  logic                  i_start,
  input  logic                  i_clear,
  input  logic                  i_out_ready,
  output logic                  o_out_valid,
  output logic [FIELD_W-1:0]    o_out_data,
  output logic [3:0]            o_out_field,
  output logic [ADDR_WIDTH-1:0] o_out_row,
  output logic                  o_out_eor,
  output logic                  o_out_last,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err_ovf
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);
  localparam logic [11:0]           DEPTH_N = 12'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_LOADED, ST_STREAM, ST_DONE} state_t;

  state_t r_state;
  state_t w_state_next;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  logic [3:0]            r_feat;
  logic [ADDR_WIDTH-1:0] r_last_row;
  logic [ADDR_WIDTH-1:0] r_iss_row;
  logic [3:0]            r_iss_field;
  logic                  r_iss_active;

  logic                  r_b_valid;
  logic [ADDR_WIDTH-1:0] r_b_row;
  logic [3:0]            r_b_field;
  logic                  r_b_eor;
  logic                  r_b_last;

  logic                  r_out_valid;
  logic [FIELD_W-1:0]    r_out_data;
  logic [3:0]            r_out_field;
  logic [ADDR_WIDTH-1:0] r_out_row;
  logic                  r_out_eor;
  logic                  r_out_last;
  logic                  r_done;
  logic                  r_err_ovf;

  logic                  w_wr_state;
  logic                  w_wr_ok;
  logic                  w_wr_bad;
  logic                  w_start_acc;
  logic [11:0]           w_eff_rows;
  logic                  w_adv;
  logic                  w_final;
  logic                  w_rd_en;
  logic                  w_iss_eor;
  logic                  w_iss_last;
  logic [3:0]            w_sel;
  logic [FIELD_W-1:0]    w_fields [MAX_FEATURES+1];

  assign w_wr_state  = (r_state == ST_IDLE) || (r_state == ST_LOADED);
  assign w_wr_ok     = i_wr_en && w_wr_state && (i_wr_addr <  DEPTH_A);
  assign w_wr_bad    = i_wr_en && w_wr_state && (i_wr_addr >= DEPTH_A);
  assign w_start_acc = i_start && !i_clear && ((r_state == ST_LOADED) || (r_state == ST_DONE));
  assign w_eff_rows  = (i_num_dp > DEPTH_N) ? DEPTH_N : i_num_dp;

  // The pipeline (issue -> RAM register -> output register) advances whenever the
  // output slot is empty or being accepted, giving one field per cycle at full rate.
  assign w_adv      = !r_out_valid || i_out_ready;
  assign w_final    = r_out_valid && i_out_ready && r_out_last;
  assign w_rd_en    = (r_state == ST_STREAM) && w_adv && r_iss_active && !i_clear;
  assign w_iss_eor  = (r_iss_field == r_feat);
  assign w_iss_last = w_iss_eor && (r_iss_row == r_last_row);

  // Used fields sit at the top of the row, so field k lives in slot MAX_FEATURES-feat+k.
  assign w_sel = 4'(MAX_FEATURES) - r_feat + r_b_field;

  generate
    for (genvar gi = 0; gi <= MAX_FEATURES; gi++) begin : g_field
      assign w_fields[gi] = r_rd_data[gi*FIELD_W +: FIELD_W];
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (w_wr_ok)
      r_mem[i_wr_addr[IDX_W-1:0]] <= i_wr_data;
    if (w_rd_en)
      r_rd_data <= r_mem[r_iss_row[IDX_W-1:0]];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (i_clear) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (i_load_done) w_state_next = ST_LOADED;
        ST_LOADED,
        ST_DONE:   if (i_start) w_state_next = (w_eff_rows == 12'd0) ? ST_DONE : ST_STREAM;
        ST_STREAM: if (w_final) w_state_next = ST_DONE;
        default:   w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_feat       <= '0;
      r_last_row   <= '0;
      r_iss_row    <= '0;
      r_iss_field  <= '0;
      r_iss_active <= 1'b0;
      r_b_valid    <= 1'b0;
      r_b_row      <= '0;
      r_b_field    <= '0;
      r_b_eor      <= 1'b0;
      r_b_last     <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_field  <= '0;
      r_out_row    <= '0;
      r_out_eor    <= 1'b0;
      r_out_last   <= 1'b0;
      r_done       <= 1'b0;
      r_err_ovf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_wr_bad || (w_start_acc && (i_num_dp > DEPTH_N)))
        r_err_ovf <= 1'b1;

      if (i_clear) begin
        r_iss_active <= 1'b0;
        r_b_valid    <= 1'b0;
        r_out_valid  <= 1'b0;
      end else if (w_start_acc) begin
        r_feat       <= i_feat;
        r_last_row   <= ADDR_WIDTH'(w_eff_rows) - 1'b1;
        r_iss_row    <= '0;
        r_iss_field  <= '0;
        r_iss_active <= (w_eff_rows != 12'd0);
        r_b_valid    <= 1'b0;
        r_out_valid  <= 1'b0;
        r_done       <= (w_eff_rows == 12'd0);
      end else if ((r_state == ST_STREAM) && w_adv) begin
        if (w_final)
          r_done <= 1'b1;
        r_out_valid <= r_b_valid;
        if (r_b_valid) begin
          r_out_data  <= w_fields[w_sel];
          r_out_field <= r_b_field;
          r_out_row   <= r_b_row;
          r_out_eor   <= r_b_eor;
          r_out_last  <= r_b_last;
        end
        r_b_valid <= r_iss_active;
        if (r_iss_active) begin
          r_b_row   <= r_iss_row;
          r_b_field <= r_iss_field;
          r_b_eor   <= w_iss_eor;
          r_b_last  <= w_iss_last;
          if (w_iss_last)
            r_iss_active <= 1'b0;
          if (w_iss_eor) begin
            r_iss_field <= '0;
            r_iss_row   <= r_iss_row + 1'b1;
          end else begin
            r_iss_field <= r_iss_field + 1'b1;
          end
        end
      end
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_field = r_out_field;
  assign o_out_row   = r_out_row;
  assign o_out_eor   = r_out_eor;
  assign o_out_last  = r_out_last;
  assign o_busy      = (r_state == ST_STREAM);
  assign o_done      = r_done;
  assign o_err_ovf   = r_err_ovf;

endmodule

// File: tb/tb_dataset_row_streamer.sv
// Scoreboard bench for dataset_row_streamer: expected fields are queued at start and
// popped on each accepted transfer.
module tb_dataset_row_streamer;
  localparam int DW = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [11:0]   num_dp;
  logic [3:0]    feat;
  logic          wr_en;
  logic [11:0]   wr_addr;
  logic [DW-1:0] wr_data;
  logic          load_done;
  logic          start;
  logic          clear;
  logic          out_ready;
  logic          out_valid;
  logic [15:0]   out_data;
  logic [3:0]    out_field;
  logic [11:0]   out_row;
  logic          out_eor;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          err_ovf;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  field;
    logic [11:0] row;
    logic        eor;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dataset_row_streamer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_num_dp(num_dp), .i_feat(feat),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_load_done(load_done), .i_start(start), .i_clear(clear),
    .i_out_ready(out_ready), .o_out_valid(out_valid), .o_out_data(out_data),
    .o_out_field(out_field), .o_out_row(out_row), .o_out_eor(out_eor),
    .o_out_last(out_last), .o_busy(busy), .o_done(done), .o_err_ovf(err_ovf)
  );

  function automatic logic [15:0] fval(int r, int k);
    return 16'(32'h0A00 + (r << 4) + k);
  endfunction

  // Unused slots get filler so a wrong field offset shows up as a data error.
  function automatic logic [DW-1:0] make_row(int r, int f);
    logic [DW-1:0] v;
    v = '0;
    for (int j = 0; j < 16; j++) v[j*16 +: 16] = 16'hDEAD ^ 16'(j);
    for (int k = 0; k <= f; k++) v[DW - 16*(f+1) + 16*k +: 16] = fval(r, k);
    return v;
  endfunction

  task automatic push_exp(input int n, input int f);
    exp_t e;
    for (int r = 0; r < n; r++)
      for (int k = 0; k <= f; k++) begin
        e.data = fval(r, k); e.field = 4'(k); e.row = 12'(r);
        e.eor = (k == f); e.last = (r == n-1) && (k == f);
        sb.push_back(e);
      end
  endtask

  task automatic load_rows(input int n, input int f);
    clear = 1'b1; @(posedge clk); #1; clear = 1'b0;
    for (int r = 0; r < n; r++) begin
      wr_en = 1'b1; wr_addr = 12'(r); wr_data = make_row(r, f);
      load_done = (r == n-1);
      @(posedge clk); #1;
    end
    wr_en = 1'b0; load_done = 1'b0;
  endtask

  task automatic do_start(input int n, input int f);
    num_dp = 12'(n); feat = 4'(f); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic run_stream(input string name, input bit toggle);
    int cyc = 0, ph = 0, last_x = -10;
    bit seen_done = 0, stalled = 0, any = 0;
    logic [15:0] h_data; logic [3:0] h_field; logic [11:0] h_row; logic h_eor, h_last;
    exp_t e;
    while (!seen_done && cyc < 3000) begin
      out_ready = toggle ? ((ph % 4 == 0) || (ph % 4 == 3)) : 1'b1;
      @(negedge clk);
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== h_data || out_field !== h_field ||
            out_row !== h_row || out_eor !== h_eor || out_last !== h_last) begin
          failures++;
          $display("FAIL %s_stall_hold: got v=%b d=%h f=%0d r=%0d, required v=1 d=%h f=%0d r=%0d",
                   name, out_valid, out_data, out_field, out_row, h_data, h_field, h_row);
        end
      end
      if (!toggle && any && sb.size() > 0) begin
        checks++;
        if (out_valid !== 1'b1) begin
          failures++;
          $display("FAIL %s_gap: out_valid=%b with %0d fields pending, required 1", name, out_valid, sb.size());
        end
      end
      if (out_valid === 1'b1) any = 1;
      if (done === 1'b1) begin
        seen_done = 1;
        checks++;
        if (sb.size() != 0 || out_valid !== 1'b0 || cyc != last_x + 1) begin
          failures++;
          $display("FAIL %s_done: pending=%0d valid=%b cyc=%0d, required 0/0/%0d", name, sb.size(), out_valid, cyc, last_x + 1);
        end
      end else if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        last_x = cyc;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL %s_extra: unexpected field d=%h r=%0d f=%0d", name, out_data, out_row, out_field);
        end else begin
          e = sb.pop_front();
          if (out_data !== e.data || out_field !== e.field || out_row !== e.row ||
              out_eor !== e.eor || out_last !== e.last) begin
            failures++;
            $display("FAIL %s_field: got d=%h f=%0d r=%0d eor=%b last=%b, required d=%h f=%0d r=%0d eor=%b last=%b",
                     name, out_data, out_field, out_row, out_eor, out_last, e.data, e.field, e.row, e.eor, e.last);
          end else
            $display("xfer %s row=%0d field=%0d data=%h eor=%b last=%b", name, out_row, out_field, out_data, out_eor, out_last);
        end
      end
      stalled = (out_valid === 1'b1) && !out_ready;
      h_data = out_data; h_field = out_field; h_row = out_row; h_eor = out_eor; h_last = out_last;
      @(posedge clk); #1; cyc++; ph++;
    end
    checks++;
    if (!seen_done) begin
      failures++;
      $display("FAIL %s_timeout: no done within budget, %0d fields pending", name, sb.size());
      sb.delete();
    end else begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL %s_after_done: done=%b busy=%b valid=%b, required 0/0/0", name, done, busy, out_valid);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; num_dp = '0; feat = '0; wr_en = 0; wr_addr = '0; wr_data = '0;
    load_done = 0; start = 0; clear = 0; out_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, out_data, out_field, out_row, out_eor, out_last, busy, done, err_ovf} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b d=%h busy=%b done=%b err=%b, required all 0", out_valid, out_data, busy, done, err_ovf);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset released");
  endtask

  task automatic test_basic();
    do_start(3, 2);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL idle_start_ignored: busy=%b, required 0", busy);
    end
    @(posedge clk); #1;
    load_rows(3, 2);
    push_exp(3, 2);
    out_ready = 1'b0;
    do_start(3, 2);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL latency_n0: valid=%b busy=%b, required 0/1", out_valid, busy);
    end
    @(posedge clk); #1; @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL latency_n1: valid=%b, required 0", out_valid);
    end
    @(posedge clk); #1; @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++; $display("FAIL latency_n2: valid=%b, required 1", out_valid);
    end
    @(posedge clk); #1;
    run_stream("basic", 1'b0);
  endtask

  task automatic test_stall();
    push_exp(3, 2);
    do_start(3, 2);
    run_stream("stall", 1'b1);
  endtask

  task automatic test_empty();
    bit saw_valid = 0;
    do_start(0, 2);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL empty_done: done=%b valid=%b busy=%b, required 1/0/0", done, out_valid, busy);
    end
    @(posedge clk); #1; @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++; $display("FAIL empty_done_width: done=%b, required 0", done);
    end
    for (int i = 0; i < 5; i++) begin
      if (out_valid === 1'b1) saw_valid = 1;
      @(negedge clk);
    end
    checks++;
    if (saw_valid) begin
      failures++; $display("FAIL empty_no_valid: out_valid seen, required none");
    end
    @(posedge clk); #1;
    $display("empty dataset done");
  endtask

  task automatic test_overflow();
    load_rows(10, 0);
    checks++;
    if (err_ovf !== 1'b0) begin
      failures++; $display("FAIL ovf_clean: err_ovf=%b, required 0", err_ovf);
    end
    wr_en = 1'b1; wr_addr = 12'd10; wr_data = '1; @(posedge clk); #1;
    wr_addr = 12'd19; @(posedge clk); #1;
    wr_en = 1'b0;
    @(negedge clk);
    checks++;
    if (err_ovf !== 1'b1) begin
      failures++; $display("FAIL ovf_write: err_ovf=%b, required 1", err_ovf);
    end
    @(posedge clk); #1;
    push_exp(10, 0);
    do_start(12, 0);
    run_stream("ovf", 1'b0);
  endtask

  task automatic test_wide();
    load_rows(2, 15);
    push_exp(2, 15);
    do_start(2, 15);
    run_stream("wide", 1'b0);
  endtask

  task automatic test_abort();
    bit found = 0, saw_done = 0;
    load_rows(3, 2);
    out_ready = 1'b1;
    do_start(3, 2);
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_row == 12'd1 && out_field == 4'd1) found = 1;
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL abort_reach: row 1 field 1 never presented");
    end
    rst_n = 1'b0; #1;
    checks++;
    if ({out_valid, out_data, out_field, out_row, out_eor, out_last, busy, done, err_ovf} !== '0) begin
      failures++;
      $display("FAIL abort_reset: got v=%b d=%h r=%0d busy=%b done=%b err=%b, required all 0", out_valid, out_data, out_row, busy, done, err_ovf);
    end
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    load_rows(3, 2);
    out_ready = 1'b1;
    do_start(3, 2);
    repeat (4) begin @(posedge clk); #1; end
    clear = 1'b1; @(posedge clk); #1; clear = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL clear_stream: valid=%b busy=%b, required 0/0", out_valid, busy);
    end
    for (int i = 0; i < 5; i++) begin
      if (done === 1'b1) saw_done = 1;
      @(negedge clk);
    end
    checks++;
    if (saw_done) begin
      failures++; $display("FAIL clear_no_done: done pulsed after clear");
    end
    @(posedge clk); #1;
    do_start(3, 2);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL clear_idle_start: busy=%b, required 0", busy);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    $display("abort tests done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_empty();
    test_overflow();
    test_wide();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
